// File: rtl/spram_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single 16K x 16 SPRAM.
// Each 32-bit access runs as a low halfword beat, a high halfword beat, then a one-cycle ack.
module spram_arbiter #(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p1_req,
    input  logic [3:0]    p0_be,
    input  logic [3:0]    p1_be,
    input  logic [AW-1:0] p0_addr,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p0_wdata,
    input  logic [31:0]   p1_wdata,
    output logic [31:0]   p0_rdata,
    output logic [31:0]   p1_rdata,
    output logic          p0_ack,
    output logic          p1_ack,
    output logic          busy,
    output logic [3:0]    spram_we,
    output logic [AW:0]   spram_addr,
    output logic [15:0]   spram_wdata,
    input  logic [15:0]   spram_rdata
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic                win;
    logic [3:0]          be_q, be_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [15:0]         rlo_q, rlo_d;
    logic [31:0]         rdata_full;
    logic [1:0]          ack;
    logic [1:0][31:0]    rdata_w;

    // The high half comes straight from the SPRAM in DONE so ack and data align.
    assign rdata_full = {spram_rdata, rlo_q};
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rlo_d       = rlo_q;
        spram_we    = 4'b0000;
        spram_addr  = '0;
        spram_wdata = 16'h0000;
        // On a tie the port that was not granted last wins.
        win         = p0_req ? (p1_req & ~last_q) : p1_req;

        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    state_d = LO;
                    grant_d = win;
                    last_d  = win;
                    be_d    = win ? p1_be    : p0_be;
                    addr_d  = win ? p1_addr  : p0_addr;
                    wdata_d = win ? p1_wdata : p0_wdata;
                end
            end
            LO: begin
                spram_we    = {be_q[1], be_q[1], be_q[0], be_q[0]};
                spram_addr  = {addr_q, 1'b0};
                spram_wdata = wdata_q[15:0];
                state_d     = HI;
            end
            HI: begin
                spram_we    = {be_q[3], be_q[3], be_q[2], be_q[2]};
                spram_addr  = {addr_q, 1'b1};
                spram_wdata = wdata_q[31:16];
                rlo_d       = spram_rdata;
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            be_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rlo_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rlo_q   <= rlo_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        localparam logic PORT = (gi == 1);
        logic [31:0] hold_q;

        assign ack[gi]     = (state_q == DONE) && (grant_q == PORT);
        assign rdata_w[gi] = ack[gi] ? rdata_full : hold_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                hold_q <= 32'h0;
            end else begin
                hold_q <= rdata_w[gi];
            end
        end
    end

    assign p0_ack   = ack[0];
    assign p1_ack   = ack[1];
    assign p0_rdata = rdata_w[0];
    assign p1_rdata = rdata_w[1];

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter: SPRAM behavioural model plus a word-level
// reference memory and transaction scheduler; directed scenarios then random traffic.
module tb_spram_arbiter;
    localparam int AW = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [1:0]          req;
    logic [1:0][3:0]     be;
    logic [1:0][AW-1:0]  addr;
    logic [1:0][31:0]    wdata;
    logic [31:0]         p0_rdata, p1_rdata;
    logic                p0_ack, p1_ack, busy;
    logic [3:0]          spram_we;
    logic [13:0]         spram_addr;
    logic [15:0]         spram_wdata, spram_rdata;
    logic [1:0][31:0]    rdata;
    logic [1:0]          ack;

    assign rdata[0] = p0_rdata;
    assign rdata[1] = p1_rdata;
    assign ack[0]   = p0_ack;
    assign ack[1]   = p1_ack;

    spram_arbiter #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(req[0]), .p1_req(req[1]),
        .p0_be(be[0]), .p1_be(be[1]),
        .p0_addr(addr[0]), .p1_addr(addr[1]),
        .p0_wdata(wdata[0]), .p1_wdata(wdata[1]),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .p0_ack(p0_ack), .p1_ack(p1_ack),
        .busy(busy),
        .spram_we(spram_we), .spram_addr(spram_addr),
        .spram_wdata(spram_wdata), .spram_rdata(spram_rdata)
    );

    // SPRAM: nibble-masked write, registered read of the old contents.
    logic [15:0] sp_mem [16384];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (spram_we[i]) sp_mem[spram_addr][4*i +: 4] <= spram_wdata[4*i +: 4];
        spram_rdata <= sp_mem[spram_addr];
    end

    // Reference: 32-bit word memory and an access scheduler (idle -> lo -> hi -> ack).
    logic [31:0]       ref_mem [8192];
    int                ph, cur, last_p;
    logic [3:0]        m_be;
    logic [AW-1:0]     m_addr;
    logic [31:0]       m_wdata;
    logic [1:0][31:0]  hold_exp;
    logic [1:0]        hold_ok, granted, done_flag;
    int                cyc, n_chk, n_fail, n_txn;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Applies the decision made at the coming clock edge, using the inputs as they stand.
    task automatic advance();
        if (rst) begin
            ph = 0; last_p = 1; granted = '0; hold_exp = '0; hold_ok = 2'b11;
        end else if (ph == 0) begin
            if (req != 2'b00) begin
                if (req == 2'b11) cur = 1 - last_p;
                else              cur = req[1] ? 1 : 0;
                last_p = cur;
                m_be = be[cur]; m_addr = addr[cur]; m_wdata = wdata[cur];
                granted[cur] = 1'b1;
                ph = 1;
            end
        end else begin
            ph = (ph + 1) % 4;
        end
    endtask

    task automatic check();
        logic [3:0]  exp_we;
        logic [31:0] word;
        done_flag = '0;
        chk_val("busy", 32'(busy), 32'(ph != 0));
        exp_we = 4'b0000;
        if (ph == 1) exp_we = {m_be[1], m_be[1], m_be[0], m_be[0]};
        if (ph == 2) exp_we = {m_be[3], m_be[3], m_be[2], m_be[2]};
        chk_val("spram_we", 32'(spram_we), 32'(exp_we));
        if (ph == 1 || ph == 2) begin
            chk_val("spram_addr", 32'(spram_addr), 32'({m_addr, 1'(ph == 2)}));
            chk_val("spram_wdata", 32'(spram_wdata),
                    (ph == 1) ? 32'(m_wdata[15:0]) : 32'(m_wdata[31:16]));
        end
        for (int p = 0; p < 2; p++) begin
            bit mine;
            mine = (ph == 3) && (cur == p);
            chk_val("ack", 32'(ack[p]), 32'(mine));
            if (mine) begin
                word = ref_mem[m_addr];
                if (m_be == 4'b0000) begin
                    chk_val("rdata", rdata[p], word);
                    hold_exp[p] = word;
                    hold_ok[p]  = 1'b1;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (m_be[b]) word[8*b +: 8] = m_wdata[8*b +: 8];
                    ref_mem[m_addr] = word;
                    hold_ok[p] = 1'b0;
                end
                granted[p] = 1'b0;
                done_flag[p] = 1'b1;
                n_txn++;
                $display("txn %0d cycle %0d: port %0d %s addr=%h be=%h wdata=%h rdata=%h",
                         n_txn, cyc, p, (m_be == 0) ? "rd" : "wr", m_addr, m_be, m_wdata, rdata[p]);
            end else if (hold_ok[p]) begin
                chk_val("rdata_hold", rdata[p], hold_exp[p]);
            end
        end
    endtask

    task automatic tick();
        advance();
        @(posedge clk);
        #1;
        cyc++;
        check();
    endtask

    // Runs one access from an idle arbiter; optionally garbles the inputs once granted.
    task automatic access(input int p, input logic [3:0] b, input logic [AW-1:0] a,
                          input logic [31:0] d, input bit scramble,
                          output logic [31:0] rd, output int lat);
        bit got;
        got = 1'b0; lat = 0; rd = 32'h0;
        req[p] = 1'b1; be[p] = b; addr[p] = a; wdata[p] = d;
        while (!got && lat < 12) begin
            tick();
            lat++;
            got = done_flag[p];
            if (scramble && granted[p] && !got) begin
                addr[p] = ~a; wdata[p] = ~d; be[p] = ~b; req[p] = 1'b0;
            end
        end
        chk_val("ack_seen", 32'(got), 32'd1);
        rd = rdata[p];
        req[p] = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int lat, n_ack, t_prev;

        rst = 1'b1; req = '0; be = '0; addr = '0; wdata = '0;
        ph = 0; cur = 0; last_p = 1; m_be = 0; m_addr = 0; m_wdata = 0;
        hold_exp = '0; hold_ok = '0; granted = '0; done_flag = '0;
        cyc = 0; n_chk = 0; n_fail = 0; n_txn = 0;
        for (int i = 0; i < 16384; i++) sp_mem[i] = 16'h0;
        for (int i = 0; i < 8192; i++)  ref_mem[i] = 32'h0;

        // Reset held two cycles, then quiet.
        repeat (2) begin
            tick();
            chk_val("rst_spram_addr", 32'(spram_addr), 32'h0);
            chk_val("rst_spram_wdata", 32'(spram_wdata), 32'h0);
        end
        rst = 1'b0;
        repeat (20) tick();

        // Full write then read on port 0.
        access(0, 4'hF, 13'h0123, 32'hDEADBEEF, 1'b0, rd, lat);
        chk_val("latency_wr", 32'(lat), 32'd3);
        access(0, 4'h0, 13'h0123, 32'h0, 1'b0, rd, lat);
        chk_val("latency_rd", 32'(lat), 32'd3);
        chk_val("readback_full", rd, 32'hDEADBEEF);

        // Single-byte write; inputs changed after grant must be ignored.
        access(0, 4'b0100, 13'h0123, 32'h00AA0000, 1'b1, rd, lat);
        access(0, 4'h0, 13'h0123, 32'h0, 1'b0, rd, lat);
        chk_val("readback_mask", rd, 32'hDEAABEEF);

        // Top address on port 1.
        access(1, 4'hF, 13'h1FFF, 32'h12345678, 1'b0, rd, lat);
        chk_val("sp_3ffe", 32'(sp_mem[14'h3FFE]), 32'h5678);
        chk_val("sp_3fff", 32'(sp_mem[14'h3FFF]), 32'h1234);
        access(1, 4'h0, 13'h1FFF, 32'h0, 1'b0, rd, lat);
        chk_val("readback_top", rd, 32'h12345678);
        access(0, 4'h0, 13'h0000, 32'h0, 1'b0, rd, lat);
        chk_val("addr0_untouched", rd, 32'h0);

        // Reset during the HI beat.
        req[0] = 1'b1; be[0] = 4'hF; addr[0] = 13'h0040; wdata[0] = 32'hCAFEF00D;
        tick(); tick();
        chk_val("in_hi_beat", 32'(ph), 32'd2);
        rst = 1'b1; req[0] = 1'b0;
        tick();
        chk_val("rst_mid_we", 32'(spram_we), 32'h0);
        chk_val("rst_mid_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();
        access(0, 4'h0, 13'h0123, 32'h0, 1'b0, rd, lat);
        chk_val("latency_after_rst", 32'(lat), 32'd3);
        chk_val("readback_after_rst", rd, 32'hDEAABEEF);

        // Tie: both ports request continuously straight out of reset.
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        req = 2'b11; be = '0; addr[0] = 13'h0123; addr[1] = 13'h1FFF;
        n_ack = 0; t_prev = cyc;
        repeat (40) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (done_flag[p]) begin
                    chk_val("tie_order", 32'(p), 32'(n_ack % 2));
                    chk_val("tie_spacing", 32'(cyc - t_prev), (n_ack == 0) ? 32'd3 : 32'd4);
                    t_prev = cyc;
                    n_ack++;
                end
            end
        end
        chk_val("tie_ack_count", 32'(n_ack), 32'd10);
        req = 2'b00;
        repeat (5) tick();

        // Random traffic from both ports.
        repeat (600) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (done_flag[p] || (!req[p] && !granted[p])) begin
                    if ($urandom_range(0, 3) != 0) begin
                        req[p]   = 1'b1;
                        be[p]    = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
                        addr[p]  = ($urandom_range(0, 7) == 0) ? AW'(8191 - $urandom_range(0, 3))
                                                               : AW'($urandom_range(0, 15));
                        wdata[p] = $urandom;
                    end else begin
                        req[p] = 1'b0;
                    end
                end else if (granted[p] && $urandom_range(0, 3) == 0) begin
                    addr[p]  = AW'($urandom);
                    wdata[p] = $urandom;
                    be[p]    = 4'($urandom);
                    req[p]   = 1'($urandom_range(0, 1));
                end
            end
        end
        req = 2'b00;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
